// File: rtl/cnn_accel_pkg.sv
// Shared definitions for the CNN accelerator: tile scheduler state encoding
// and the K/S-trimmed step helper shared with the out_fm store engine.
package cnn_accel_pkg;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_COMP_ISSUE  = 3'd1;
    localparam logic [2:0] ST_COMP_WAIT   = 3'd2;
    localparam logic [2:0] ST_STORE_ISSUE = 3'd3;
    localparam logic [2:0] ST_STORE_WAIT  = 3'd4;
    localparam logic [2:0] ST_ADVANCE     = 3'd5;
    localparam logic [2:0] ST_FINISH      = 3'd6;

    // Largest multiple of S that still leaves room for a full K window in span.
    function automatic int step_len(input int span, input int k, input int s);
        return ((span + s - k) / s) * s;
    endfunction

endpackage

// File: rtl/out_fm_tile_scheduler_tile_base_gen.sv
// Tile base registers (n, row, col) with col-innermost walk order and the
// combinational last_tile flag.
module tile_base_gen
    import cnn_accel_pkg::*;
#(
    parameter int AW = 16,
    parameter int N  = 32,
    parameter int R  = 64,
    parameter int C  = 32,
    parameter int K  = 3,
    parameter int S  = 1,
    parameter int Tn = 8,
    parameter int Tr = 16,
    parameter int Tc = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [AW-1:0] base_n,
    output logic [AW-1:0] base_row,
    output logic [AW-1:0] base_col,
    output logic          last_tile
);

    localparam logic [AW:0] ROW_INC = (AW+1)'(step_len(Tr, K, S));
    localparam logic [AW:0] COL_INC = (AW+1)'(step_len(Tc, K, S));
    localparam logic [AW:0] ROW_LIM = (AW+1)'(step_len(R, K, S));
    localparam logic [AW:0] COL_LIM = (AW+1)'(step_len(C, K, S));
    localparam logic [AW:0] N_INC   = (AW+1)'(Tn);
    localparam logic [AW:0] N_LIM   = (AW+1)'(N);

    // One extra bit keeps the wrap comparison exact near the top of the AW range.
    logic [AW:0] col_nxt, row_nxt, n_nxt;
    logic        col_wrap, row_wrap, n_wrap;

    assign col_nxt  = {1'b0, base_col} + COL_INC;
    assign row_nxt  = {1'b0, base_row} + ROW_INC;
    assign n_nxt    = {1'b0, base_n}   + N_INC;
    assign col_wrap = (col_nxt >= COL_LIM);
    assign row_wrap = (row_nxt >= ROW_LIM);
    assign n_wrap   = (n_nxt >= N_LIM);

    assign last_tile = col_wrap && row_wrap && n_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_n   <= '0;
            base_row <= '0;
            base_col <= '0;
        end else if (clear) begin
            base_n   <= '0;
            base_row <= '0;
            base_col <= '0;
        end else if (advance) begin
            if (col_wrap) begin
                base_col <= '0;
                if (row_wrap) begin
                    base_row <= '0;
                    base_n   <= n_nxt[AW-1:0];
                end else begin
                    base_row <= row_nxt[AW-1:0];
                end
            end else begin
                base_col <= col_nxt[AW-1:0];
            end
        end
    end

endmodule

// File: rtl/out_fm_tile_scheduler.sv
// Output-feature-map tile sequencer: compute then store each tile, pulse done at the end.
// Optional TILE_SCHED_PERF_EN adds cyc_comp / cyc_store / tile_cnt performance counters.
module out_fm_tile_scheduler
    import cnn_accel_pkg::*;
#(
    parameter int AW = 16,
    parameter int N  = 32,
    parameter int R  = 64,
    parameter int C  = 32,
    parameter int K  = 3,
    parameter int S  = 1,
    parameter int Tn = 8,
    parameter int Tr = 16,
    parameter int Tc = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          done,
    output logic          busy,
    output logic          comp_start,
    input  logic          comp_done,
    output logic          store_start,
    input  logic          store_done,
    output logic [AW-1:0] tile_base_n,
    output logic [AW-1:0] tile_base_row,
    output logic [AW-1:0] tile_base_col,
    output logic          last_tile
`ifdef TILE_SCHED_PERF_EN
    ,
    output logic [31:0]   cyc_comp,
    output logic [31:0]   cyc_store,
    output logic [15:0]   tile_cnt
`endif
);

    logic [2:0] state, state_nxt;
    logic       start_acc;

    assign start_acc = (state == ST_IDLE) && start;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:        if (start) state_nxt = ST_COMP_ISSUE;
            ST_COMP_ISSUE:  state_nxt = ST_COMP_WAIT;
            ST_COMP_WAIT:   if (comp_done) state_nxt = ST_STORE_ISSUE;
            ST_STORE_ISSUE: state_nxt = ST_STORE_WAIT;
            ST_STORE_WAIT:  if (store_done) state_nxt = last_tile ? ST_FINISH : ST_ADVANCE;
            ST_ADVANCE:     state_nxt = ST_COMP_ISSUE;
            ST_FINISH:      state_nxt = ST_IDLE;
            default:        state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Pulses decode straight from the registered state, so each lasts exactly one cycle.
    assign comp_start  = (state == ST_COMP_ISSUE);
    assign store_start = (state == ST_STORE_ISSUE);
    assign done        = (state == ST_FINISH);
    assign busy        = (state != ST_IDLE);

    tile_base_gen #(
        .AW(AW), .N(N), .R(R), .C(C), .K(K), .S(S), .Tn(Tn), .Tr(Tr), .Tc(Tc)
    ) u_base_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_acc),
        .advance  (state == ST_ADVANCE),
        .base_n   (tile_base_n),
        .base_row (tile_base_row),
        .base_col (tile_base_col),
        .last_tile(last_tile)
    );

`ifdef TILE_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_comp  <= '0;
            cyc_store <= '0;
            tile_cnt  <= '0;
        end else if (start_acc) begin
            cyc_comp  <= '0;
            cyc_store <= '0;
            tile_cnt  <= '0;
        end else begin
            if ((state == ST_COMP_WAIT) && !(&cyc_comp))
                cyc_comp <= cyc_comp + 32'd1;
            if ((state == ST_STORE_WAIT) && !(&cyc_store))
                cyc_store <= cyc_store + 32'd1;
            if ((state == ST_STORE_WAIT) && store_done && !(&tile_cnt))
                tile_cnt <= tile_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_out_fm_tile_scheduler.sv
// Directed bench for out_fm_tile_scheduler: small 18-tile layer and a single-tile layer.
module tb_out_fm_tile_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0, done, busy, comp_start, comp_done, store_start, store_done, last_tile;
    logic [15:0] bn, br, bc;
    logic        start_s = 1'b0, done_s, busy_s, comp_start_s, comp_done_s, store_start_s, store_done_s, last_tile_s;
    logic [15:0] bn_s, br_s, bc_s;
`ifdef TILE_SCHED_PERF_EN
    logic [31:0] cyc_comp, cyc_store, cyc_comp_s, cyc_store_s;
    logic [15:0] tile_cnt, tile_cnt_s;
`endif

    out_fm_tile_scheduler #(
        .AW(16), .N(4), .R(8), .C(8), .K(3), .S(1), .Tn(2), .Tr(4), .Tc(4)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
        .comp_start(comp_start), .comp_done(comp_done),
        .store_start(store_start), .store_done(store_done),
        .tile_base_n(bn), .tile_base_row(br), .tile_base_col(bc), .last_tile(last_tile)
`ifdef TILE_SCHED_PERF_EN
        , .cyc_comp(cyc_comp), .cyc_store(cyc_store), .tile_cnt(tile_cnt)
`endif
    );

    out_fm_tile_scheduler #(
        .AW(16), .N(2), .R(4), .C(4), .K(3), .S(1), .Tn(8), .Tr(16), .Tc(16)
    ) u_single (
        .clk(clk), .rst(rst), .start(start_s), .done(done_s), .busy(busy_s),
        .comp_start(comp_start_s), .comp_done(comp_done_s),
        .store_start(store_start_s), .store_done(store_done_s),
        .tile_base_n(bn_s), .tile_base_row(br_s), .tile_base_col(bc_s), .last_tile(last_tile_s)
`ifdef TILE_SCHED_PERF_EN
        , .cyc_comp(cyc_comp_s), .cyc_store(cyc_store_s), .tile_cnt(tile_cnt_s)
`endif
    );

    // Responders: done pulse is sampled by the DUT 3 cycles after the start pulse.
    logic [3:0] csr = '0, ssr = '0, csr_s = '0, ssr_s = '0;
    logic       glitch_sd = 1'b0;
    int         n_cs = 0, n_ss = 0, n_cs_s = 0;

    always @(negedge clk) begin
        if (rst) begin
            csr = '0; ssr = '0; csr_s = '0; ssr_s = '0;
            n_cs = 0; n_ss = 0; n_cs_s = 0;
        end else begin
            csr   = {csr[2:0], comp_start};
            ssr   = {ssr[2:0], store_start};
            csr_s = {csr_s[2:0], comp_start_s};
            ssr_s = {ssr_s[2:0], store_start_s};
            if (comp_start)   n_cs++;
            if (store_start)  n_ss++;
            if (comp_start_s) n_cs_s++;
        end
    end

    assign comp_done    = csr[3];
    assign store_done   = ssr[3] | glitch_sd;
    assign comp_done_s  = csr_s[3];
    assign store_done_s = ssr_s[3];

    int nchecks = 0;
    int nerr    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return comp_start;
            1:       return store_start;
            2:       return store_done;
            3:       return store_start_s;
            4:       return store_done_s;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (sig_of(sel)) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // mode 0: clean layer, 1: glitch injection, 2: reset during STORE_WAIT of tile 5
    task automatic run_layer(input int mode);
        bit ok;
        int cs0, ss0;
        int en, er, ec;
        cs0 = n_cs;
        ss0 = n_ss;
        @(negedge clk); start = 1'b1;
        step();
        start = 1'b0;
        chk("start_to_comp_start", 32'(comp_start), 32'd1);
        chk("busy_after_start", 32'(busy), 32'd1);
`ifdef TILE_SCHED_PERF_EN
        chk("perf_clear_tile_cnt", 32'(tile_cnt), 32'd0);
        chk("perf_clear_cyc_comp", cyc_comp, 32'd0);
        chk("perf_clear_cyc_store", cyc_store, 32'd0);
`endif
        for (int i = 0; i < 18; i++) begin
            en = (i / 9) * 2;
            er = ((i / 3) % 3) * 2;
            ec = (i % 3) * 2;
            wait_for(0, 20, ok);
            chk("comp_start_seen", 32'(ok), 32'd1);
            chk("base_n", 32'(bn), 32'(en));
            chk("base_row", 32'(br), 32'(er));
            chk("base_col", 32'(bc), 32'(ec));
            chk("last_tile", 32'(last_tile), 32'(i == 17));
            if (mode == 1 && i == 4) begin
                start = 1'b1; glitch_sd = 1'b1;
                step();
                step();
                start = 1'b0; glitch_sd = 1'b0;
                chk("glitch_no_store_start", 32'(store_start), 32'd0);
            end
            wait_for(1, 20, ok);
            chk("store_start_seen", 32'(ok), 32'd1);
            chk("store_base_n", 32'(bn), 32'(en));
            chk("store_base_row", 32'(br), 32'(er));
            chk("store_base_col", 32'(bc), 32'(ec));
            if (mode == 2 && i == 5) begin
                step();
                rst = 1'b1;
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_comp_start", 32'(comp_start), 32'd0);
                chk("rst_store_start", 32'(store_start), 32'd0);
                chk("rst_bases", 32'({bn, br | bc}), 32'd0);
`ifdef TILE_SCHED_PERF_EN
                chk("rst_tile_cnt", 32'(tile_cnt), 32'd0);
`endif
                step();
                step();
                rst = 1'b0;
                step();
                chk("post_rst_idle", 32'(busy), 32'd0);
                return;
            end
            wait_for(2, 20, ok);
            chk("store_done_seen", 32'(ok), 32'd1);
            if (i < 17) begin
                chk("advance_no_comp_start", 32'(comp_start), 32'd0);
                chk("advance_no_done", 32'(done), 32'd0);
                step();
                chk("store_done_to_comp_start", 32'(comp_start), 32'd1);
            end else begin
                chk("last_store_done_to_done", 32'(done), 32'd1);
                chk("busy_during_done", 32'(busy), 32'd1);
                if (mode == 1) start = 1'b1;
                step();
                start = 1'b0;
                chk("done_one_cycle", 32'(done), 32'd0);
                chk("busy_falls", 32'(busy), 32'd0);
                chk("no_restart_after_done", 32'(comp_start), 32'd0);
                step();
                chk("stay_idle", 32'(busy), 32'd0);
            end
        end
        chk("comp_start_total", 32'(n_cs - cs0), 32'd18);
        chk("store_start_total", 32'(n_ss - ss0), 32'd18);
`ifdef TILE_SCHED_PERF_EN
        chk("perf_tile_cnt", 32'(tile_cnt), 32'd18);
        chk("perf_cyc_comp", cyc_comp, 32'd54);
        chk("perf_cyc_store", cyc_store, 32'd54);
`endif
    endtask

    initial begin
        bit ok;
        rst = 1'b1;
        step();
        step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_comp_start", 32'(comp_start), 32'd0);
        chk("reset_store_start", 32'(store_start), 32'd0);
        chk("reset_base_n", 32'(bn), 32'd0);
        chk("reset_base_row", 32'(br), 32'd0);
        chk("reset_base_col", 32'(bc), 32'd0);
        chk("reset_last_tile", 32'(last_tile), 32'd0);
        chk("reset_single_busy", 32'(busy_s), 32'd0);
        rst = 1'b0;
        step();

        run_layer(0);
        run_layer(1);
        run_layer(2);
        run_layer(0);

        @(negedge clk); start_s = 1'b1;
        step();
        start_s = 1'b0;
        chk("single_comp_start", 32'(comp_start_s), 32'd1);
        chk("single_last_tile", 32'(last_tile_s), 32'd1);
        chk("single_bases", 32'({bn_s, br_s | bc_s}), 32'd0);
        wait_for(3, 20, ok);
        chk("single_store_start_seen", 32'(ok), 32'd1);
        chk("single_last_at_store", 32'(last_tile_s), 32'd1);
        wait_for(4, 20, ok);
        chk("single_store_done_seen", 32'(ok), 32'd1);
        chk("single_done", 32'(done_s), 32'd1);
        step();
        chk("single_busy_falls", 32'(busy_s), 32'd0);
        chk("single_comp_pairs", 32'(n_cs_s), 32'd1);
`ifdef TILE_SCHED_PERF_EN
        chk("single_tile_cnt", 32'(tile_cnt_s), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
